// File: rtl/moa_pkg.sv
// rtl/moa_pkg.sv - shared constants and state type for the serial carry-propagate stage
// Purpose: operand/result widths, bit-counter width and FSM state encoding.
// Ports: none (package).
package moa_pkg;

    localparam int MOA_W     = 5;
    localparam int MOA_RW    = MOA_W + 2;
    localparam int MOA_CNT_W = $clog2(MOA_RW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } moa_state_e;

endpackage

// File: rtl/moa_fa1.sv
// rtl/moa_fa1.sv - single-bit full adder used as the serial resolution cell
// Purpose: s = a ^ b ^ ci, co = majority(a, b, ci).
// Ports: a, b, ci (in, 1 bit each); s, co (out, 1 bit each).
module moa_fa1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/moa_cpa_serial.sv
// rtl/moa_cpa_serial.sv - bit-serial resolver of a carry-save pair into Y = S + 2*C
// Purpose: accept {S, C} on a valid/ready handshake, resolve one bit per clock
//          through one full-adder cell, hold Y until the consumer takes it.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with S, C (W bits);
//        out_valid/out_ready with Y (RW bits); busy (high while resolving).
module moa_cpa_serial
    import moa_pkg::*;
#(
    parameter int W  = MOA_W,
    parameter int RW = W + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  S,
    input  logic [W-1:0]  C,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] Y,
    output logic          busy
);

    localparam int CNT_W = $clog2(RW);

    moa_state_e       state_q, state_d;
    logic [RW-1:0]    a_q, a_d;
    logic [RW-1:0]    b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic [RW-1:0]    res_q, res_d;
    logic [RW-1:0]    y_q, y_d;
    logic             fa_s;
    logic             fa_co;

    moa_fa1 u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (cy_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        res_d   = res_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                // rst never reaches here while high: the register block overrides it.
                if (in_valid) begin
                    a_d     = {2'b00, S};
                    b_d     = {1'b0, C, 1'b0};
                    cnt_d   = '0;
                    cy_d    = 1'b0;
                    res_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // LSB-first: each sum bit enters at the MSB so after RW
                // shifts bit 0 of the result sits at res[0].
                res_d = {fa_s, res_q[RW-1:1]};
                a_d   = {1'b0, a_q[RW-1:1]};
                b_d   = {1'b0, b_q[RW-1:1]};
                cy_d  = fa_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(RW - 1)) begin
                    // Y gets its own register so it keeps the last completed
                    // value while the next pair is being shifted in.
                    y_d     = {fa_s, res_q[RW-1:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            res_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            res_q   <= res_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ADD);
    assign Y         = y_q;

endmodule
